// File: rtl/mem_access_unit.sv
// Data-memory initiator: one load/store at a time, sub-word stores done as
// read-modify-write on a word-only memory port, response over valid/ready.
module mem_access_unit #(
    parameter int ADDR_BITS = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        ReqValid,
    output logic        ReqReady,
    input  logic        ReqWrite,
    input  logic [1:0]  ReqSize,
    input  logic        ReqSigned,
    input  logic [31:0] ReqAddr,
    input  logic [31:0] ReqWData,
    output logic        RspValid,
    input  logic        RspReady,
    output logic [31:0] RspData,
    output logic        RspErr,
    output logic [31:0] ALU_Result,
    output logic [31:0] WriteMemData,
    output logic        MemWrite,
    output logic        MemRead,
    input  logic [31:0] ReadMemData
);

    typedef enum logic [2:0] {
        IDLE, LD_RD, LD_CAP, ST_RD, ST_MRG, ST_WR, RESP
    } state_t;

    state_t      state_q;
    logic        req_ready_q;
    logic        rsp_valid_q;
    logic        rsp_err_q;
    logic [31:0] rsp_data_q;
    logic [31:0] alu_q;
    logic [31:0] wmd_q;
    logic [1:0]  size_q;
    logic        signed_q;

    logic        addr_err;
    logic [31:0] ld_ext;
    logic [31:0] st_merge;

    assign addr_err = |ReqAddr[31:ADDR_BITS];

    always_comb begin
        ld_ext   = ReadMemData;
        st_merge = {ReadMemData[31:16], wmd_q[15:0]};
        case (size_q)
            2'b00: begin
                ld_ext   = {{24{signed_q & ReadMemData[7]}}, ReadMemData[7:0]};
                st_merge = {ReadMemData[31:8], wmd_q[7:0]};
            end
            2'b01: ld_ext = {{16{signed_q & ReadMemData[15]}}, ReadMemData[15:0]};
            default: ld_ext = ReadMemData;
        endcase
    end

    // Ready re-arms only after a full cycle in IDLE, which guarantees the
    // idle gap between a response handshake and the next accept.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            req_ready_q <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_err_q   <= 1'b0;
            rsp_data_q  <= 32'd0;
            alu_q       <= 32'd0;
            wmd_q       <= 32'd0;
            size_q      <= 2'b00;
            signed_q    <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    req_ready_q <= 1'b1;
                    if (ReqValid && req_ready_q) begin
                        req_ready_q <= 1'b0;
                        size_q      <= ReqSize;
                        signed_q    <= ReqSigned;
                        alu_q       <= {{(32-ADDR_BITS){1'b0}}, ReqAddr[ADDR_BITS-1:0]};
                        rsp_err_q   <= 1'b0;
                        rsp_data_q  <= 32'd0;
                        if (addr_err) begin
                            state_q     <= RESP;
                            rsp_valid_q <= 1'b1;
                            rsp_err_q   <= 1'b1;
                        end else if (!ReqWrite) begin
                            state_q <= LD_RD;
                        end else begin
                            wmd_q   <= ReqWData;
                            state_q <= ReqSize[1] ? ST_WR : ST_RD;
                        end
                    end
                end
                LD_RD:  state_q <= LD_CAP;
                LD_CAP: begin
                    rsp_data_q  <= ld_ext;
                    rsp_valid_q <= 1'b1;
                    state_q     <= RESP;
                end
                ST_RD:  state_q <= ST_MRG;
                ST_MRG: begin
                    wmd_q   <= st_merge;
                    state_q <= ST_WR;
                end
                ST_WR: begin
                    rsp_valid_q <= 1'b1;
                    state_q     <= RESP;
                end
                RESP: begin
                    if (RspReady) begin
                        rsp_valid_q <= 1'b0;
                        state_q     <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign ReqReady     = req_ready_q;
    assign RspValid     = rsp_valid_q;
    assign RspErr       = rsp_err_q;
    assign RspData      = rsp_data_q;
    assign ALU_Result   = alu_q;
    assign WriteMemData = wmd_q;
    assign MemRead      = (state_q == LD_RD) || (state_q == ST_RD);
    assign MemWrite     = (state_q == ST_WR);

endmodule
